// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
//   Per-pixel HDMI period sequencer. From the raster position (cx, cy) it
//   picks the period each TMDS channel encoder runs in: control, video
//   preamble / guard band, active video, data-island preamble / guard band
//   and island data. It grants 32-cycle packet slots to an upstream packet
//   source whenever the horizontal blanking interval has room for them.
//
//   All outputs are registered: the values seen on cycle t+1 are computed
//   from cx/cy/packet_valid sampled on cycle t.
//
// Ports
//   clk_pixel     in   pixel clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   cx            in   pixel column, wraps at FRAME_WIDTH
//   cy            in   line number, advances when cx wraps
//   packet_valid  in   upstream has a packet ready for the next slot
//   mode          out  0=control 1=video 2=video guard 3=island 4=island guard
//   ctl           out  CTL3..CTL0 preamble bits during control periods
//   packet_accept out  1-cycle pulse on the first data cycle of each packet
//   packet_phase  out  0..31 index within the current packet, else 0
//   island_active out  high from island preamble through trailing guard band
//   dbg_state     out  current island FSM state (IDLE=0 PRE=1 LGB=2 DATA=3 TGB=4 COOL=5)
//
// Handshake: packet_valid is sampled only when an island may start (FSM
// idle) and on the last cycle of a packet (phase 31). A packet is consumed
// on the cycle packet_accept is high; deasserting packet_valid while a
// packet is in flight has no effect on that packet.
module hdmi_period_scheduler #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAME_WIDTH   = 800,
    parameter int FRAME_HEIGHT  = 525,
    parameter int BIT_WIDTH     = 10,
    parameter int BIT_HEIGHT    = 10,
    parameter int MAX_PACKETS   = 2
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic                  packet_valid,
    output logic [2:0]            mode,
    output logic [3:0]            ctl,
    output logic                  packet_accept,
    output logic [4:0]            packet_phase,
    output logic                  island_active,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_LGB  = 3'd2,
        S_DATA = 3'd3,
        S_TGB  = 3'd4,
        S_COOL = 3'd5
    } state_e;

    localparam logic [2:0] M_CTRL      = 3'd0;
    localparam logic [2:0] M_VIDEO     = 3'd1;
    localparam logic [2:0] M_VGUARD    = 3'd2;
    localparam logic [2:0] M_ISLAND    = 3'd3;
    localparam logic [2:0] M_IGUARD    = 3'd4;

    // Wide enough that cx plus the longest look-ahead never wraps.
    localparam int XW  = BIT_WIDTH + 7;
    localparam int CYW = BIT_HEIGHT + 1;
    localparam logic [XW-1:0] PRE_LIMIT = XW'(FRAME_WIDTH - 10);

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [4:0]     pkt_q, pkt_d;

    logic [2:0]     mode_q, mode_d;
    logic [3:0]     ctl_q, ctl_d;
    logic           accept_q, accept_d;
    logic [4:0]     phase_q, phase_d;
    logic           active_q, active_d;

    logic [XW-1:0]  cx_ext;
    logic [CYW-1:0] cy_ext, cy_next;
    logic           next_active, video_active, vid_pre, vid_guard;
    logic           fit_one, chain_ok, start_zone, abort_zone;

    // Raster decode.
    assign cx_ext       = XW'(cx);
    assign cy_ext       = CYW'(cy);
    assign cy_next      = (cy_ext == CYW'(FRAME_HEIGHT - 1)) ? '0 : cy_ext + CYW'(1);
    assign next_active  = cy_next < CYW'(SCREEN_HEIGHT);
    assign video_active = (cx_ext < XW'(SCREEN_WIDTH)) && (cy_ext < CYW'(SCREEN_HEIGHT));
    assign abort_zone   = cx_ext >= PRE_LIMIT;
    assign vid_pre      = next_active && abort_zone && (cx_ext <= XW'(FRAME_WIDTH - 3));
    assign vid_guard    = next_active && (cx_ext >= XW'(FRAME_WIDTH - 2));

    // One-packet island (12 overhead + 32 data) plus 12 control cycles must
    // finish before the video preamble region.
    assign fit_one    = (cx_ext + XW'(12 + 32 + 12)) <= PRE_LIMIT;
    // Chaining one more packet from phase 31: rest of this cycle, 32 data,
    // 2 trailing guard, 12 control.
    assign chain_ok   = (cx_ext + XW'(1 + 32 + 2 + 12)) <= PRE_LIMIT;
    assign start_zone = cx_ext >= XW'(SCREEN_WIDTH + 4);

    // State and output registers.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pkt_q    <= '0;
            mode_q   <= M_CTRL;
            ctl_q    <= '0;
            accept_q <= 1'b0;
            phase_q  <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pkt_q    <= pkt_d;
            mode_q   <= mode_d;
            ctl_q    <= ctl_d;
            accept_q <= accept_d;
            phase_q  <= phase_d;
            active_q <= active_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        pkt_d   = pkt_q;
        if (state_q != S_IDLE && abort_zone) begin
            // Never let an island run into the video preamble.
            state_d = S_IDLE;
            cnt_d   = '0;
            pkt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    pkt_d = '0;
                    if (packet_valid && start_zone && fit_one) state_d = S_PRE;
                end
                S_PRE: if (cnt_q == 5'd7) begin
                    state_d = S_LGB;
                    cnt_d   = '0;
                end
                S_LGB: if (cnt_q == 5'd1) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    pkt_d   = 5'd1;
                end
                S_DATA: if (cnt_q == 5'd31) begin
                    cnt_d = '0;
                    if (packet_valid && (pkt_q < 5'(MAX_PACKETS)) && chain_ok) begin
                        pkt_d = pkt_q + 5'd1;
                    end else begin
                        state_d = S_TGB;
                    end
                end
                S_TGB: if (cnt_q == 5'd1) begin
                    state_d = S_COOL;
                    cnt_d   = '0;
                end
                S_COOL: if (cnt_q == 5'd3) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pkt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the state being entered; video path overrides.
    always_comb begin
        mode_d   = M_CTRL;
        ctl_d    = 4'b0000;
        accept_d = 1'b0;
        phase_d  = '0;
        active_d = 1'b0;
        unique case (state_d)
            S_PRE: begin
                ctl_d    = 4'b0101;
                active_d = 1'b1;
            end
            S_LGB, S_TGB: begin
                mode_d   = M_IGUARD;
                active_d = 1'b1;
            end
            S_DATA: begin
                mode_d   = M_ISLAND;
                phase_d  = cnt_d;
                accept_d = (cnt_d == 5'd0);
                active_d = 1'b1;
            end
            default: ;
        endcase
        if (video_active || vid_pre || vid_guard) begin
            ctl_d    = 4'b0000;
            accept_d = 1'b0;
            phase_d  = '0;
            active_d = 1'b0;
            if (video_active) begin
                mode_d = M_VIDEO;
            end else if (vid_pre) begin
                mode_d = M_CTRL;
                ctl_d  = 4'b0001;
            end else begin
                mode_d = M_VGUARD;
            end
        end
    end

    assign mode          = mode_q;
    assign ctl           = ctl_q;
    assign packet_accept = accept_q;
    assign packet_phase  = phase_q;
    assign island_active = active_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler at 640x480 in an 800x525 frame,
// MAX_PACKETS=2. The bench drives the raster itself, one pixel per clock,
// and compares the packed outputs {mode, ctl, accept, phase, active} after
// each edge against hand-derived values.
module tb_hdmi_period_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] cx;
  logic [9:0] cy;
  logic       packet_valid;
  logic [2:0] mode;
  logic [3:0] ctl;
  logic       packet_accept;
  logic [4:0] packet_phase;
  logic       island_active;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  hdmi_period_scheduler #(
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .FRAME_WIDTH(800),
    .FRAME_HEIGHT(525), .BIT_WIDTH(10), .BIT_HEIGHT(10), .MAX_PACKETS(2)
  ) dut (
    .clk_pixel(clk),
    .reset_n(reset_n),
    .cx(cx),
    .cy(cy),
    .packet_valid(packet_valid),
    .mode(mode),
    .ctl(ctl),
    .packet_accept(packet_accept),
    .packet_phase(packet_phase),
    .island_active(island_active),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // driver: present (x, y) before the edge, sample #1 after it
  task automatic drive(input int x, input int y);
    @(negedge clk);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pk(input int m, input int c, input int a, input int p, input int i);
    return {3'(m), 4'(c), 1'(a), 5'(p), 1'(i)};
  endfunction

  function automatic logic [13:0] got_out();
    return {mode, ctl, packet_accept, packet_phase, island_active};
  endfunction

  // Expected outputs when no island is in progress.
  function automatic logic [13:0] base_exp(input int x, input int y);
    int  nxt;
    bit  na;
    nxt = (y == 524) ? 0 : y + 1;
    na  = nxt < 480;
    if (x < 640 && y < 480) return pk(1, 0, 0, 0, 0);
    if (na && x >= 790 && x <= 797) return pk(0, 1, 0, 0, 0);
    if (na && x >= 798) return pk(2, 0, 0, 0, 0);
    return pk(0, 0, 0, 0, 0);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    cx = '0;
    cy = '0;
    packet_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_out() !== 14'h0) $display("FAIL reset_outputs got=%h exp=%h", got_out(), 14'h0);
    if (got_out() !== 14'h0) errors++;
    checks++;
    if (dbg_state !== 3'd0) begin
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
      errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_video_line(input int y);
    logic [13:0] e;
    packet_valid = 1'b0;
    for (int x = 0; x < 800; x++) begin
      drive(x, y);
      e = base_exp(x, y);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL video_line y=%0d x=%0d got=%h exp=%h", y, x, got_out(), e);
        errors++;
      end
    end
  endtask

  // Island starting at 644 with two chained packets; valid dropped mid
  // second packet so no further island is requested on this line.
  task automatic test_island(input int y);
    logic [13:0] e;
    packet_valid = 1'b0;
    for (int x = 0; x < 640; x++) drive(x, y);
    packet_valid = 1'b1;
    for (int x = 640; x < 800; x++) begin
      if (x == 700) packet_valid = 1'b0;
      drive(x, y);
      if (x >= 644 && x <= 651)      e = pk(0, 5, 0, 0, 1);
      else if (x >= 652 && x <= 653) e = pk(4, 0, 0, 0, 1);
      else if (x >= 654 && x <= 685) e = pk(3, 0, (x == 654), x - 654, 1);
      else if (x >= 686 && x <= 717) e = pk(3, 0, (x == 686), x - 686, 1);
      else if (x >= 718 && x <= 719) e = pk(4, 0, 0, 0, 1);
      else                           e = base_exp(x, y);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL island y=%0d x=%0d got=%h exp=%h", y, x, got_out(), e);
        errors++;
      end
    end
  endtask

  // 734 is the last column where fit(1) holds; 735 must not start.
  task automatic test_fit_boundary();
    logic [13:0] e;
    packet_valid = 1'b0;
    for (int x = 0; x < 734; x++) drive(x, 30);
    packet_valid = 1'b1;
    for (int x = 734; x < 800; x++) begin
      if (x == 750) packet_valid = 1'b0;
      drive(x, 30);
      if (x >= 734 && x <= 741)      e = pk(0, 5, 0, 0, 1);
      else if (x >= 742 && x <= 743) e = pk(4, 0, 0, 0, 1);
      else if (x >= 744 && x <= 775) e = pk(3, 0, (x == 744), x - 744, 1);
      else if (x >= 776 && x <= 777) e = pk(4, 0, 0, 0, 1);
      else                           e = base_exp(x, 30);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL fit_pass x=%0d got=%h exp=%h", x, got_out(), e);
        errors++;
      end
    end
    packet_valid = 1'b0;
    for (int x = 0; x < 735; x++) drive(x, 31);
    packet_valid = 1'b1;
    for (int x = 735; x < 800; x++) begin
      drive(x, 31);
      e = base_exp(x, 31);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL fit_reject x=%0d got=%h exp=%h", x, got_out(), e);
        errors++;
      end
    end
    // valid still high: next line starts at 644
    for (int x = 0; x < 645; x++) begin
      drive(x, 32);
      e = (x == 644) ? pk(0, 5, 0, 0, 1) : base_exp(x, 32);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL fit_next_line x=%0d got=%h exp=%h", x, got_out(), e);
        errors++;
      end
    end
    packet_valid = 1'b0;
    for (int x = 645; x < 800; x++) drive(x, 32);
  endtask

  // Raster jumps from 700 to 790 mid-island: FSM must drop to IDLE and
  // the video preamble shows immediately.
  task automatic test_abort();
    logic [13:0] e;
    packet_valid = 1'b0;
    for (int x = 0; x < 650; x++) drive(x, 10);
    packet_valid = 1'b1;
    for (int x = 650; x <= 700; x++) begin
      drive(x, 10);
      if (x <= 657)      e = pk(0, 5, 0, 0, 1);
      else if (x <= 659) e = pk(4, 0, 0, 0, 1);
      else if (x <= 691) e = pk(3, 0, (x == 660), x - 660, 1);
      else               e = pk(3, 0, (x == 692), x - 692, 1);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL abort_pre x=%0d got=%h exp=%h", x, got_out(), e);
        errors++;
      end
    end
    packet_valid = 1'b0;
    for (int x = 790; x < 800; x++) begin
      drive(x, 10);
      e = base_exp(x, 10);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL abort_jump x=%0d got=%h exp=%h", x, got_out(), e);
        errors++;
      end
      if (x == 790) begin
        checks++;
        if (dbg_state !== 3'd0) begin
          $display("FAIL abort_state got=%0d exp=0", dbg_state);
          errors++;
        end
      end
    end
    test_video_line(11);
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    packet_valid = 1'b0;
    for (int x = 0; x < 640; x++) drive(x, 20);
    packet_valid = 1'b1;
    for (int x = 640; x <= 664; x++) drive(x, 20);
    checks++;
    if (got_out() !== pk(3, 0, 0, 10, 1)) begin
      $display("FAIL reset_mid_phase10 got=%h exp=%h", got_out(), pk(3, 0, 0, 10, 1));
      errors++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (got_out() !== 14'h0 || dbg_state !== 3'd0) begin
      $display("FAIL reset_mid_async got=%h state=%0d exp=0", got_out(), dbg_state);
      errors++;
    end
    packet_valid = 1'b0;
    drive(665, 20);
    checks++;
    if (got_out() !== 14'h0) begin
      $display("FAIL reset_mid_hold got=%h exp=0", got_out());
      errors++;
    end
    reset_n = 1'b1;
    for (int x = 666; x < 800; x++) begin
      drive(x, 20);
      e = base_exp(x, 20);
      checks++;
      if (got_out() !== e) begin
        $display("FAIL reset_mid_after x=%0d got=%h exp=%h", x, got_out(), e);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_video_line(0);
    test_island(5);
    test_video_line(479);
    test_video_line(500);
    test_island(524);
    test_fit_boundary();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
